trg_seq: RTL
============

Name: trg_seq

Overview:
- Programmable internal trigger sequencer. It generates the soft-trigger pulse train consumed by the trigger/busy block on its softtrg_i input.
- It sits directly upstream of that block.
- It shares the 8-bit-address / 16-bit-data register bus with it and decodes its own register addresses.
- It issues N triggers, or runs continuously, with a programmable start delay and period, optionally holding each trigger while the global busy is high.

Parameters:
None. Register map and counter widths (32 bit) are fixed.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
reg_we_i  in  1  register write strobe
reg_addr_i  in  8  register address
reg_data_i  in  16  register write data
reg_data_o  out  16  register read data (combinational on reg_addr_i)
bsy_i  in  1  global busy from trigger/busy block
softtrg_o  out  1  registered single-cycle trigger pulse, drives softtrg_i downstream
running_o  out  1  sequencer active (state != IDLE)
done_o  out  1  single-cycle pulse when sequence completes normally

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; softtrg_o=0; done_o=0; running_o=0.
  - sent=0; ntrg=1; period=0; delay=0; ctrl=0; done_sticky=0.
- Register map (write only with reg_we_i=1; 32-bit values are split into a low and a high word):
  - 0x00 STATUS (RO): {13'b0, done_sticky, holding, running}.
  - 0x01 CTRL (RW): bit0 wait_bsy, bit1 continuous; reads {14'b0, ctrl}.
  - 0x02 CMD (WO): data 0x0000=START, 0x0001=STOP, other values ignored; reads as STATUS.
  - 0x03/0x04 NTRG lo/hi.
  - 0x05/0x06 PERIOD lo/hi.
  - 0x07/0x08 DELAY lo/hi.
  - 0x09/0x0A SENT lo/hi (RO).
  - Any other address reads 16'hF001.
- States: IDLE, DELAY, PERIOD. One 32-bit down-counter cnt is used in both DELAY and PERIOD.
- START (edge e0), from any state:
  - Sets sent=0, done_sticky=0, cnt=delay, state=DELAY. A START while running restarts the sequence.
  - If ntrg==0 and continuous==0, START is ignored and the state is unchanged.
- Fire condition: in DELAY or PERIOD, at an edge where cnt==0.
  - If wait_bsy=1 and bsy_i=1: stay, cnt stays 0, holding=1, no pulse.
  - Otherwise, at that edge:
    - softtrg_o<=1 for exactly one cycle;
    - sent<=sent+1, saturating at 0xFFFFFFFF;
    - holding<=0;
    - cnt<=max(period,1)-1;
    - state<=PERIOD.
- Not at a fire edge: if cnt!=0, cnt decrements; softtrg_o<=0.
- Timing:
  - With delay=D, the first pulse is high in the cycle after edge e0+D+1.
  - Pulse spacing is max(period,1) cycles. Period 0 and period 1 both give a pulse every cycle.
- Completion: if continuous==0 and (sent+1)>=ntrg at a fire edge:
  - the pulse is issued as normal;
  - at the same edge state<=IDLE, done_o<=1 for one cycle (coincident with the last softtrg_o), done_sticky<=1.
- STOP in any state:
  - Next edge: state=IDLE, softtrg_o=0, holding=0.
  - No done pulse; sent is preserved.
- START and STOP cannot coincide (single CMD address).
- Live updates during a run:
  - NTRG is compared live. If lowered to <= sent, the run ends at the next fire edge, which still issues its pulse.
  - PERIOD takes effect at the next cnt reload.
  - DELAY takes effect only on the next START.
- Continuous mode ignores ntrg and runs until STOP; sent saturates at 0xFFFFFFFF.
- Reset asserted mid-run aborts immediately to reset values with no done pulse.
- running_o = (state != IDLE), registered.

Test Plan:
- Reset, then read all registers: STATUS=0x0000, NTRG lo=0x0001, NTRG hi/PERIOD/DELAY/SENT=0, address 0x20 reads 0xF001.
- ntrg=3, period=10, delay=5, START at edge e0 -> pulses after e6, e16 and e26; done_o coincident with the third pulse; SENT=3; STATUS=0x0004.
- period=0, ntrg=4, delay=0 -> four pulses in consecutive cycles starting 1 cycle after START; running_o drops after the fourth.
- wait_bsy=1, period=4, bsy_i held high for 7 cycles across the second fire edge -> second pulse occurs on the first edge with bsy_i low, STATUS.holding=1 while held, following pulses spaced 4 from it; wait_bsy=0 with the same stimulus -> pulse ignores bsy_i.
- continuous=1, period=2, STOP after 5 pulses -> no further pulses, done_o never asserted, SENT=5; a subsequent START clears SENT to 0.
- Mid-run checks: ntrg=0 with START -> nothing happens; NTRG rewritten to 1 after 2 pulses -> run ends on the next pulse (SENT=3); rst_i mid-run -> outputs 0 asynchronously, no done_o.

Source files
------------

// File: rtl/trg_seq.sv
// Programmable soft-trigger sequencer: N or continuous triggers with start delay,
// period and optional hold-off while the global busy is asserted.
module trg_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_we_i,
  input  logic [7:0]  reg_addr_i,
  input  logic [15:0] reg_data_i,
  output logic [15:0] reg_data_o,
  input  logic        bsy_i,
  output logic        softtrg_o,
  output logic        running_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_PERIOD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] r_sent;
  logic [31:0] r_ntrg;
  logic [31:0] r_period;
  logic [31:0] r_delay;
  logic [1:0]  r_ctrl;
  logic        r_done_sticky;
  logic        r_holding;
  logic        r_softtrg;
  logic        r_done;
  logic        r_running;

  logic        w_cmd;
  logic        w_start;
  logic        w_stop;
  logic        w_active;
  logic        w_fire_edge;
  logic        w_blocked;
  logic        w_fire;
  logic        w_last;
  logic [32:0] w_sent_inc;
  logic [31:0] w_reload;
  logic [15:0] w_status;

  // A START with nothing to send (ntrg 0, not continuous) is treated as no command.
  assign w_cmd   = reg_we_i && (reg_addr_i == 8'h02);
  assign w_start = w_cmd && (reg_data_i == 16'h0000) && ((r_ntrg != 32'd0) || r_ctrl[1]);
  assign w_stop  = w_cmd && (reg_data_i == 16'h0001);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_DELAY;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_fire) begin
      w_state_nxt = w_last ? ST_IDLE : ST_PERIOD;
    end
  end

  // Commands take priority over a fire edge falling on the same clock.
  always_comb begin
    w_active    = (r_state != ST_IDLE);
    w_fire_edge = w_active && (r_cnt == 32'd0) && !w_start && !w_stop;
    w_blocked   = w_fire_edge && r_ctrl[0] && bsy_i;
    w_fire      = w_fire_edge && !w_blocked;
    w_sent_inc  = {1'b0, r_sent} + 33'd1;
    w_last      = w_fire && !r_ctrl[1] && (w_sent_inc >= {1'b0, r_ntrg});
    w_reload    = (r_period == 32'd0) ? 32'd0 : (r_period - 32'd1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt         <= 32'd0;
      r_sent        <= 32'd0;
      r_done_sticky <= 1'b0;
      r_holding     <= 1'b0;
      r_softtrg     <= 1'b0;
      r_done        <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      r_softtrg <= w_fire;
      r_done    <= w_last;
      r_running <= (w_state_nxt != ST_IDLE);
      if (w_start) begin
        r_cnt         <= r_delay;
        r_sent        <= 32'd0;
        r_done_sticky <= 1'b0;
        r_holding     <= 1'b0;
      end else if (w_stop) begin
        r_holding <= 1'b0;
      end else if (w_fire) begin
        r_cnt     <= w_reload;
        r_holding <= 1'b0;
        if (!w_sent_inc[32]) begin
          r_sent <= w_sent_inc[31:0];
        end
        if (w_last) begin
          r_done_sticky <= 1'b1;
        end
      end else if (w_blocked) begin
        r_holding <= 1'b1;
      end else if (w_active && (r_cnt != 32'd0)) begin
        r_cnt <= r_cnt - 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ctrl   <= 2'd0;
      r_ntrg   <= 32'd1;
      r_period <= 32'd0;
      r_delay  <= 32'd0;
    end else if (reg_we_i) begin
      case (reg_addr_i)
        8'h01: r_ctrl           <= reg_data_i[1:0];
        8'h03: r_ntrg[15:0]     <= reg_data_i;
        8'h04: r_ntrg[31:16]    <= reg_data_i;
        8'h05: r_period[15:0]   <= reg_data_i;
        8'h06: r_period[31:16]  <= reg_data_i;
        8'h07: r_delay[15:0]    <= reg_data_i;
        8'h08: r_delay[31:16]   <= reg_data_i;
        default: ;
      endcase
    end
  end

  assign w_status = {13'b0, r_done_sticky, r_holding, r_running};

  always_comb begin
    reg_data_o = 16'hF001;
    case (reg_addr_i)
      8'h00, 8'h02: reg_data_o = w_status;
      8'h01:        reg_data_o = {14'b0, r_ctrl};
      8'h03:        reg_data_o = r_ntrg[15:0];
      8'h04:        reg_data_o = r_ntrg[31:16];
      8'h05:        reg_data_o = r_period[15:0];
      8'h06:        reg_data_o = r_period[31:16];
      8'h07:        reg_data_o = r_delay[15:0];
      8'h08:        reg_data_o = r_delay[31:16];
      8'h09:        reg_data_o = r_sent[15:0];
      8'h0A:        reg_data_o = r_sent[31:16];
      default:      reg_data_o = 16'hF001;
    endcase
  end

  assign softtrg_o = r_softtrg;
  assign done_o    = r_done;
  assign running_o = r_running;

endmodule
